counter_pulse_gen: RTL

Pulse-train generator that drives the enable/reset pulse interface of the 4-bit pulse counter. It accepts a binary count through a valid/ready request. It then emits an optional single clear pulse followed by exactly that many enable pulses, one clock apart or separated by idle gaps. It sits upstream of the counter and is used both as on-chip stimulus and as a self-check source: emitted pulses must equal the counter's final value.

---
 rtl/counter_pulse_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/counter_pulse_gen.sv
// counter_pulse_gen: emits an optional clear pulse followed by N enable
// pulses to a downstream pulse counter. The pulses can be back-to-back or
// spaced by GAP idle cycles. All outputs decode from state flops only, so
// there is no combinational path from inputs to pulses.
module counter_pulse_gen #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_count,
  input  logic             req_clear,
  input  logic             abort,
  output logic             en_out,
  output logic             rst_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] emitted
);

  // The gap counter needs at least one bit, even when gaps are disabled.
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_EMIT, S_GAP, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] remaining;
  logic [GW-1:0]    gap_cnt;
  logic             accept;

  assign accept = req_valid && (state == S_IDLE);

  // State register
  always_ff @(posedge GCLK_Pad or posedge rst_Pad) begin
    if (rst_Pad) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic. Abort takes priority in every active state, so an
  // abort and a normal finish on the same edge produce only one DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_clear)            state_nxt = S_CLEAR;
          else if (req_count == '0) state_nxt = S_DONE;
          else                      state_nxt = S_EMIT;
        end
      end
      S_CLEAR: begin
        if (abort || remaining == '0) state_nxt = S_DONE;
        else                          state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (abort || remaining == WIDTH'(1)) state_nxt = S_DONE;
        else if (GAP > 0)                    state_nxt = S_GAP;
        else                                 state_nxt = S_EMIT;
      end
      S_GAP: begin
        if (abort)                     state_nxt = S_DONE;
        else if (gap_cnt == GW'(1))    state_nxt = S_EMIT;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: the pulse tally and the gap timer. A pulse still counts when
  // abort arrives during its own cycle.
  always_ff @(posedge GCLK_Pad or posedge rst_Pad) begin
    if (rst_Pad) begin
      remaining <= '0;
      emitted   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (accept) begin
        remaining <= req_count;
        emitted   <= '0;
      end else if (state == S_EMIT) begin
        remaining <= remaining - WIDTH'(1);
        emitted   <= emitted + WIDTH'(1);
      end
      if (state == S_EMIT && state_nxt == S_GAP) gap_cnt <= GW'(GAP);
      else if (state == S_GAP)                   gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Output decode (state flops only)
  always_comb begin
    en_out    = (state == S_EMIT);
    rst_out   = (state == S_CLEAR);
    done      = (state == S_DONE);
    busy      = (state != S_IDLE);
    req_ready = (state == S_IDLE);
  end

endmodule
